cla_pipelined_subtractor: RTL and testbench
===========================================

CLA_PIPELINED_SUBTRACTOR -- requirements
Module: cla_pipelined_subtractor

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 16 bits, organised as four 4-bit lookahead groups.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand beat present.
REQ-005 in_ready  output  1  block accepts beat this cycle.
REQ-006 A  input  16  minuend.
REQ-007 B  input  16  subtrahend.
REQ-008 Bin  input  1  borrow-in.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 Diff  output  16  A - B - Bin, modulo 2^16.
REQ-012 Bout  output  1  borrow-out: 1 when unsigned A < B + Bin.
REQ-013 Ovf  output  1  signed overflow; present only under CLA_SUB_OVF_EN.

Function
REQ-014 Arithmetic SHALL be A + ~B + ~Bin: group carry-in to nibble 0 = ~Bin; Bout = ~(carry out of nibble 3).
REQ-015 Per nibble: P[i] = A[i] ^ ~B[i], G[i] = A[i] & ~B[i]; all intra-nibble carries computed by two-level lookahead, not ripple.
REQ-016 Four pipeline stages; stage k computes nibble k and registers its sum bits, its carry-out, and the unprocessed upper operand nibbles.
REQ-017 Latency: a beat accepted at edge N SHALL appear on Diff/Bout with out_valid=1 after edge N+4, provided out_ready has stayed high.
REQ-018 Handshake: transfer on in side when in_valid & in_ready; on out side when out_valid & out_ready.
REQ-019 advance = ~out_valid | out_ready; in_ready = advance (combinational); all stage registers and valid bits load only when advance=1.
REQ-020 When advance=0, every stage register, Diff, Bout, out_valid SHALL hold unchanged; no beat lost or duplicated.
REQ-021 Throughput: one beat per cycle with out_ready held high; in_valid=0 cycles propagate as bubbles (valid bit 0).
REQ-022 Diff/Bout SHALL be registered outputs, stable while out_valid=1 and out_ready=0.
REQ-023 Beats SHALL exit in acceptance order.
REQ-024 Simultaneous accept and emit in one cycle SHALL be allowed.
REQ-025 Boundaries: 0x0000-0x0000-0 -> Diff 0x0000, Bout 0; 0x0000-0x0000-1 -> Diff 0xFFFF, Bout 1 (wrap).

Reset
REQ-026 rst_n low SHALL immediately clear all stage valid bits, out_valid, Diff, Bout (and Ovf) to 0.
REQ-027 Beats in flight at reset assertion SHALL be discarded; no result emitted for them after release.
REQ-028 in_ready SHALL be 1 during and after reset, since out_valid=0.

Configuration
REQ-029 Macro CLA_SUB_OVF_EN defined: Ovf port exists, registered alongside Diff, value (A[15]^B[15]) & (A[15]^Diff[15]) for the same beat; sign bits carried through the pipeline.
REQ-030 Macro CLA_SUB_OVF_EN undefined: no Ovf port and no associated sign-bit registers; all other behaviour identical.

Verification
REQ-031 Single beat A=0x1234, B=0x0234, Bin=0, out_ready=1 -> 4 edges later Diff=0x1000, Bout=0, out_valid pulse of 1 cycle.
REQ-032 A=0x0000, B=0x0001, Bin=1 -> Diff=0xFFFE, Bout=1; with CLA_SUB_OVF_EN, Ovf=0.
REQ-033 With CLA_SUB_OVF_EN, A=0x8000, B=0x0001, Bin=0 -> Diff=0x7FFF, Bout=0, Ovf=1.
REQ-034 Back-to-back stream of 8 beats with out_ready=1 -> 8 consecutive out_valid cycles, in order, results matching reference model.
REQ-035 Stall: out_ready=0 for 6 cycles mid-stream -> in_ready=0 once out_valid=1; Diff held; after release all beats emitted in order, none lost.
REQ-036 Reset asserted with 3 beats in flight -> out_valid=0 immediately; after release no stale result appears within 8 cycles.

Source files
------------

// File: rtl/cla_pipelined_subtractor.sv
// 16-bit A - B - Bin subtractor, four pipelined 4-bit carry-lookahead stages with valid/ready flow control.
// Optional signed-overflow output enabled by defining CLA_SUB_OVF_EN.
module cla_pipelined_subtractor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Diff,
    output logic        Bout
`ifdef CLA_SUB_OVF_EN
    ,
    output logic        Ovf
`endif
);

    localparam int unsigned W  = 16;
    localparam int unsigned NW = 4;

    // 4-bit two-level lookahead adder: returns {carry_out, sum}
    function automatic logic [NW:0] cla4(input logic [NW-1:0] a, input logic [NW-1:0] bn,
                                         input logic cin);
        logic [NW-1:0] p;
        logic [NW-1:0] g;
        logic [NW:0]   c;
        p    = a ^ bn;
        g    = a & bn;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[NW-1:0]};
    endfunction

    logic           advance;

    logic           in_v_q;
    logic [W-1:0]   in_a_q;
    logic [W-1:0]   in_b_q;
    logic           in_bin_q;

    logic           s0_v_q;
    logic [3:0]     s0_sum_q;
    logic           s0_c_q;
    logic [15:4]    s0_a_q;
    logic [15:4]    s0_b_q;

    logic           s1_v_q;
    logic [7:0]     s1_sum_q;
    logic           s1_c_q;
    logic [15:8]    s1_a_q;
    logic [15:8]    s1_b_q;

    logic           s2_v_q;
    logic [11:0]    s2_sum_q;
    logic           s2_c_q;
    logic [15:12]   s2_a_q;
    logic [15:12]   s2_b_q;

    logic           out_valid_q;
    logic [W-1:0]   diff_q;
    logic           bout_q;

    logic [NW:0]    n0_d;
    logic [NW:0]    n1_d;
    logic [NW:0]    n2_d;
    logic [NW:0]    n3_d;

    assign advance   = ~out_valid_q | out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign Diff      = diff_q;
    assign Bout      = bout_q;

    // Subtraction as A + ~B + ~Bin, one nibble per stage
    always_comb begin
        n0_d = cla4(in_a_q[3:0],   ~in_b_q[3:0],   ~in_bin_q);
        n1_d = cla4(s0_a_q[7:4],   ~s0_b_q[7:4],   s0_c_q);
        n2_d = cla4(s1_a_q[11:8],  ~s1_b_q[11:8],  s1_c_q);
        n3_d = cla4(s2_a_q[15:12], ~s2_b_q[15:12], s2_c_q);
    end

`ifdef CLA_SUB_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Operand sign bits ride along in the upper-nibble operand registers
    assign ovf_d = (s2_a_q[15] ^ s2_b_q[15]) & (s2_a_q[15] ^ n3_d[3]);
    assign Ovf   = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_v_q      <= 1'b0;
            in_a_q      <= '0;
            in_b_q      <= '0;
            in_bin_q    <= 1'b0;
            s0_v_q      <= 1'b0;
            s0_sum_q    <= '0;
            s0_c_q      <= 1'b0;
            s0_a_q      <= '0;
            s0_b_q      <= '0;
            s1_v_q      <= 1'b0;
            s1_sum_q    <= '0;
            s1_c_q      <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_v_q      <= 1'b0;
            s2_sum_q    <= '0;
            s2_c_q      <= 1'b0;
            s2_a_q      <= '0;
            s2_b_q      <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
        end else if (advance) begin
            in_v_q      <= in_valid;
            in_a_q      <= A;
            in_b_q      <= B;
            in_bin_q    <= Bin;

            s0_v_q      <= in_v_q;
            s0_sum_q    <= n0_d[3:0];
            s0_c_q      <= n0_d[4];
            s0_a_q      <= in_a_q[15:4];
            s0_b_q      <= in_b_q[15:4];

            s1_v_q      <= s0_v_q;
            s1_sum_q    <= {n1_d[3:0], s0_sum_q};
            s1_c_q      <= n1_d[4];
            s1_a_q      <= s0_a_q[15:8];
            s1_b_q      <= s0_b_q[15:8];

            s2_v_q      <= s1_v_q;
            s2_sum_q    <= {n2_d[3:0], s1_sum_q};
            s2_c_q      <= n2_d[4];
            s2_a_q      <= s1_a_q[15:12];
            s2_b_q      <= s1_b_q[15:12];

            out_valid_q <= s2_v_q;
            diff_q      <= {n3_d[3:0], s2_sum_q};
            bout_q      <= ~n3_d[4];
        end
    end

endmodule

// File: tb/tb_cla_pipelined_subtractor.sv
// Scoreboard bench for cla_pipelined_subtractor: directed beats, streaming, stall and reset-flush.
module tb_cla_pipelined_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Diff;
    logic        Bout;
`ifdef CLA_SUB_OVF_EN
    logic        Ovf;
`endif

    cla_pipelined_subtractor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout)
`ifdef CLA_SUB_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        b;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_asserts  = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   emit_count = 0;
    int   last_emit  = 0;
    int   last_lat   = 0;
    int   run        = 0;
    int   max_run    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
        exp_t        e;
        logic [16:0] r;
        r     = {1'b0, a} - {1'b0, b} - 17'(bin);
        e.d   = r[15:0];
        e.b   = r[16];
        e.o   = (a[15] ^ b[15]) & (a[15] ^ r[15]);
        e.cyc = 0;
        return e;
    endfunction

    // Output monitor: compares every transferred result against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("stale_or_extra_beat", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("diff", 32'(Diff), 32'(e.d));
                check("bout", 32'(Bout), 32'(e.b));
`ifdef CLA_SUB_OVF_EN
                check("ovf", 32'(Ovf), 32'(e.o));
`endif
                last_lat = cyc - e.cyc;
            end
            emit_count++;
            last_emit = cyc;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    // Called at a negedge; returns at a later negedge once the beat was accepted
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin);
        exp_t e;
        bit   done;
        done     = 0;
        in_valid = 1'b1;
        A        = a;
        B        = b;
        Bin      = bin;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (in_ready === 1'b1) begin
                e     = model(a, b, bin);
                e.cyc = cyc + 1;
                sb.push_back(e);
                done  = 1;
            end
            @(negedge clk);
        end
        if (!done) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] held;
        bit          have;
        int          ec;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        Bin       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(Diff), 32'd0);
        check("rst_bout", 32'(Bout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat: latency and one-cycle valid pulse
        ec = emit_count;
        send(16'h1234, 16'h0234, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && emit_count == ec; i++) @(negedge clk);
        check("single_emitted", 32'(emit_count - ec), 32'd1);
        check("latency", 32'(last_lat), 32'd4);
        #3;
        check("pulse_end", 32'(out_valid), 32'd0);
        @(negedge clk);

        send(16'h0000, 16'h0000, 1'b0);
        send(16'h0000, 16'h0000, 1'b1);
        send(16'h0000, 16'h0001, 1'b1);
        send(16'h8000, 16'h0001, 1'b0);
        in_valid = 1'b0;
        drain();

        // Back-to-back stream of 8 beats
        @(negedge clk);
        max_run = 0;
        ec      = emit_count;
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'h7FFF, 16'hFFFF, 1'b1);
        send(16'h0001, 16'hFFFF, 1'b0);
        for (int i = 0; i < 5; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
        in_valid = 1'b0;
        drain();
        check("stream_count", 32'(emit_count - ec), 32'd8);
        check("stream_consecutive", 32'(max_run), 32'd8);

        // Stall out_ready for 6 cycles mid-stream
        @(negedge clk);
        ec   = emit_count;
        have = 0;
        held = '0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (6) begin
                    #3;
                    if (out_valid === 1'b1) begin
                        check("stall_in_ready", 32'(in_ready), 32'd0);
                        if (!have) begin
                            held = Diff;
                            have = 1;
                        end else begin
                            check("stall_diff_held", 32'(Diff), 32'(held));
                        end
                    end
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        check("stall_seen", 32'(have), 32'd1);
        drain();
        check("stall_count", 32'(emit_count - ec), 32'd10);

        // Reset with three beats in flight
        @(negedge clk);
        send(16'h1111, 16'h0001, 1'b0);
        send(16'h2222, 16'h0002, 1'b0);
        send(16'h3333, 16'h0003, 1'b0);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        ec = emit_count;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("no_stale_after_reset", 32'(emit_count - ec), 32'd0);

        // Pipeline still healthy after flush
        send(16'h0000, 16'h0000, 1'b1);
        in_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
